gppcu_lane_write_seq: RTL and testbench
=======================================

// Module: gppcu_lane_write_seq
// PURPOSE
//   Upstream sequencer for the GPPCU one-hot lane decoder. Accepts a burst of
//   data words and steps a lane index, one word per accepted beat, starting at
//   START_LANE and wrapping modulo the lane count. LANE_IDX drives the
//   decoder's INPUT, and WR_EN gates the decoded one-hot lane write enables.
// PARAMETERS
//   EBW  4   lane index width; lane count IBW = 1 << EBW
//   DBW  32  data word width
// PORTS
//   CLK         in   1      clock, rising edge
//   RST         in   1      asynchronous reset, active-high
//   START       in   1      burst request, sampled only in IDLE
//   START_LANE  in   EBW    first lane index of the burst
//   COUNT       in   EBW+1  words in burst; 0 = empty burst; >IBW clamps to IBW
//   S_VALID     in   1      source word valid
//   S_DATA      in   DBW    source word
//   S_READY     out  1      sequencer can take a word this cycle
//   LANE_IDX    out  EBW    lane index for the decoder (registered)
//   WR_EN       out  1      lane write strobe, 1 cycle per accepted word
//   WR_DATA     out  DBW    word to write to lane LANE_IDX
//   BUSY        out  1      burst in progress
//   DONE        out  1      1-cycle pulse at burst completion
// BEHAVIOUR
//   - All outputs are registered. RST=1 clears them asynchronously:
//     S_READY=0, LANE_IDX=0, WR_EN=0, WR_DATA=0, BUSY=0, DONE=0, state=IDLE.
//   - States: IDLE, RUN.
//   - IDLE, START=1, COUNT!=0: latch idx<=START_LANE and rem<=min(COUNT,IBW).
//     Next cycle: state=RUN, BUSY=1, S_READY=1.
//   - IDLE, START=1, COUNT==0: next cycle DONE=1 for one cycle. State stays
//     IDLE, no WR_EN.
//   - START outside IDLE is ignored; latched burst values are unaffected.
//   - RUN: a beat is accepted when S_VALID & S_READY. One cycle after
//     acceptance: WR_EN=1, WR_DATA=S_DATA, LANE_IDX=idx of that beat.
//     Then idx<=idx+1 mod IBW (IBW-1 wraps to 0) and rem<=rem-1.
//   - Cycles in RUN without acceptance: WR_EN=0, and LANE_IDX/WR_DATA hold
//     their last values.
//   - Last beat (rem==1 when accepted): S_READY drops in the same edge.
//     Next cycle: WR_EN=1 and DONE=1 together, BUSY=0, state=IDLE.
//     A START in that cycle is accepted (back-to-back bursts allowed).
//   - Throughput: 1 word/cycle while S_VALID is held. No combinational path
//     from S_VALID to S_READY.
//   - Full burst (COUNT>=IBW): every lane is written exactly once, in order
//     from START_LANE, wrapping.
//   - RST during RUN aborts the burst: no DONE, no further WR_EN. Words
//     already written stay written.
//   - rem is EBW+1 bits wide, so COUNT=IBW is representable without overflow.
// TESTING
//   1. EBW=4. START, START_LANE=3, COUNT=4, S_VALID held 1 with data A..D ->
//      WR_EN on 4 consecutive cycles, LANE_IDX 3,4,5,6, DONE with beat D.
//   2. START_LANE=14, COUNT=4 -> LANE_IDX 14,15,0,1 (wrap), DONE once.
//   3. COUNT=0 -> DONE pulses 1 cycle after START, no WR_EN, BUSY stays 0.
//   4. COUNT=20 -> clamped to 16 writes; every lane 0..15 written once, from
//      START_LANE=5.
//   5. S_VALID toggling 1,0,0,1,1 with COUNT=3 -> WR_EN only after accepted
//      beats, LANE_IDX held during gaps, DONE after 3rd word.
//   6. RST asserted after 2 of 5 beats -> all outputs 0 immediately, no DONE.
//      A new START after release begins a clean burst.

Source files
------------

// File: rtl/gppcu_lane_write_seq.sv
// Burst sequencer feeding the GPPCU one-hot lane decoder.
// Steps a lane index per accepted word, wrapping over the lane count.
module gppcu_lane_write_seq #(
  parameter int EBW = 4,
  parameter int DBW = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [EBW-1:0] START_LANE,
  input  logic [EBW:0]   COUNT,
  input  logic           S_VALID,
  input  logic [DBW-1:0] S_DATA,
  output logic           S_READY,
  output logic [EBW-1:0] LANE_IDX,
  output logic           WR_EN,
  output logic [DBW-1:0] WR_DATA,
  output logic           BUSY,
  output logic           DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lane count, one bit wider than the index so the full count fits
  localparam logic [EBW:0] LANES = {1'b1, {EBW{1'b0}}};

  state_t         state, state_d;
  logic [EBW-1:0] idx, idx_d;
  logic [EBW:0]   rem, rem_d;
  logic           ready_q, ready_d;
  logic [EBW-1:0] lane_q, lane_d;
  logic           wr_q, wr_d;
  logic [DBW-1:0] data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           accept;

  // Ready is registered, so acceptance never feeds back into S_READY
  assign accept = S_VALID & ready_q;

  // State and all outputs are registered; reset abandons any burst
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= '0;
      rem     <= '0;
      ready_q <= 1'b0;
      lane_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      rem     <= rem_d;
      ready_q <= ready_d;
      lane_q  <= lane_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: latch a burst in IDLE, step one lane per accepted word in RUN
  always_comb begin
    state_d = state;
    idx_d   = idx;
    rem_d   = rem;
    ready_d = ready_q;
    lane_d  = lane_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            state_d = RUN;
            idx_d   = START_LANE;
            rem_d   = (COUNT > LANES) ? LANES : COUNT;
            ready_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          wr_d   = 1'b1;
          data_d = S_DATA;
          lane_d = idx;
          idx_d  = idx + EBW'(1);
          rem_d  = rem - (EBW+1)'(1);
          if (rem == (EBW+1)'(1)) begin
            state_d = IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign S_READY  = ready_q;
  assign LANE_IDX = lane_q;
  assign WR_EN    = wr_q;
  assign WR_DATA  = data_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_gppcu_lane_write_seq.sv
// Directed bench for gppcu_lane_write_seq.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_gppcu_lane_write_seq;

  localparam int EBW = 4;
  localparam int DBW = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           START = 1'b0;
  logic [EBW-1:0] START_LANE = '0;
  logic [EBW:0]   COUNT = '0;
  logic           S_VALID = 1'b0;
  logic [DBW-1:0] S_DATA = '0;
  logic           S_READY;
  logic [EBW-1:0] LANE_IDX;
  logic           WR_EN;
  logic [DBW-1:0] WR_DATA;
  logic           BUSY;
  logic           DONE;

  int checks = 0;
  int errors = 0;

  gppcu_lane_write_seq #(.EBW(EBW), .DBW(DBW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_LANE(START_LANE),
    .COUNT(COUNT), .S_VALID(S_VALID), .S_DATA(S_DATA),
    .S_READY(S_READY), .LANE_IDX(LANE_IDX), .WR_EN(WR_EN),
    .WR_DATA(WR_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DBW-1:0] word(input int t, input int i);
    return 32'hA000_0000 + (t << 16) + i;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({S_READY, LANE_IDX, WR_EN, WR_DATA, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b lane=%0d wr=%b data=%h busy=%b done=%b",
               S_READY, LANE_IDX, WR_EN, WR_DATA, BUSY, DONE);
    end
    step();
    RST = 1'b0;
    step();
  endtask

  // Start a burst; first word is already on S_DATA. Checks RUN entry.
  task automatic test_burst(input string nm, input int t, input int lane,
                            input int cnt, input int nw);
    int exp_lane;
    START = 1'b1;
    START_LANE = lane[EBW-1:0];
    COUNT = cnt[EBW:0];
    S_VALID = 1'b1;
    S_DATA = word(t, 0);
    step();
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || S_READY !== 1'b1 || WR_EN !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b rdy=%b wr=%b req 1 1 0",
               nm, BUSY, S_READY, WR_EN);
    end
    for (int i = 0; i < nw; i++) begin
      step();
      S_DATA = word(t, i + 1);
      exp_lane = (lane + i) % 16;
      checks++;
      if (WR_EN !== 1'b1 || LANE_IDX !== exp_lane[EBW-1:0] ||
          WR_DATA !== word(t, i) || DONE !== (i == nw - 1) ||
          BUSY !== (i != nw - 1)) begin
        errors++;
        $display("FAIL %s_beat%0d: wr=%b lane=%0d data=%h done=%b busy=%b req lane=%0d data=%h done=%b",
                 nm, i, WR_EN, LANE_IDX, WR_DATA, DONE, BUSY,
                 exp_lane, word(t, i), (i == nw - 1));
      end
    end
    S_VALID = 1'b0;
    step();
    checks++;
    if (WR_EN !== 1'b0 || DONE !== 1'b0 || S_READY !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: wr=%b done=%b rdy=%b busy=%b req all 0",
               nm, WR_EN, DONE, S_READY, BUSY);
    end
  endtask

  task automatic test_empty();
    START = 1'b1;
    START_LANE = 4'd9;
    COUNT = '0;
    step();
    START = 1'b0;
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || WR_EN !== 1'b0 || S_READY !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: done=%b busy=%b wr=%b rdy=%b req 1 0 0 0",
               DONE, BUSY, WR_EN, S_READY);
    end
    step();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || WR_EN !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: done=%b busy=%b wr=%b req 0 0 0",
               DONE, BUSY, WR_EN);
    end
  endtask

  task automatic test_full_clamp();
    int hits [16];
    int dones;
    foreach (hits[k]) hits[k] = 0;
    dones = 0;
    START = 1'b1;
    START_LANE = 4'd5;
    COUNT = 5'd20;
    S_VALID = 1'b1;
    S_DATA = word(4, 0);
    step();
    START = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step();
      S_DATA = word(4, i + 1);
      if (WR_EN) hits[LANE_IDX]++;
      if (DONE) dones++;
      if (i < 16) begin
        checks++;
        if (WR_EN !== 1'b1 || LANE_IDX !== 4'((5 + i) % 16)) begin
          errors++;
          $display("FAIL full_order%0d: wr=%b lane=%0d req 1 %0d",
                   i, WR_EN, LANE_IDX, (5 + i) % 16);
        end
      end
    end
    S_VALID = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (hits[k] !== 1) begin
        errors++;
        $display("FAIL full_lane%0d: writes=%0d req 1", k, hits[k]);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL full_done: pulses=%0d req 1", dones);
    end
    step();
  endtask

  task automatic test_gaps();
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int beat;
    START = 1'b1;
    START_LANE = 4'd7;
    COUNT = 5'd3;
    S_VALID = 1'b0;
    step();
    START = 1'b1;
    START_LANE = 4'd0;
    COUNT = 5'd1;
    beat = 0;
    for (int i = 0; i < 5; i++) begin
      S_VALID = pat[i];
      S_DATA = word(5, beat);
      step();
      if (pat[i]) beat++;
      checks++;
      if (WR_EN !== pat[i] || LANE_IDX !== 4'(7 + beat - 1) ||
          WR_DATA !== word(5, beat - 1) || DONE !== (i == 4)) begin
        errors++;
        $display("FAIL gaps%0d: wr=%b lane=%0d data=%h done=%b req %b %0d %h %b",
                 i, WR_EN, LANE_IDX, WR_DATA, DONE, pat[i],
                 7 + beat - 1, word(5, beat - 1), (i == 4));
      end
    end
    START = 1'b0;
    S_VALID = 1'b0;
    step();
    checks++;
    if (BUSY !== 1'b0 || WR_EN !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL gaps_end: busy=%b wr=%b done=%b req 0 0 0",
               BUSY, WR_EN, DONE);
    end
  endtask

  task automatic test_back_to_back();
    START = 1'b1;
    START_LANE = 4'd10;
    COUNT = 5'd1;
    S_VALID = 1'b1;
    S_DATA = word(6, 0);
    step();
    START = 1'b0;
    step();
    checks++;
    if (WR_EN !== 1'b1 || DONE !== 1'b1 || LANE_IDX !== 4'd10) begin
      errors++;
      $display("FAIL b2b_first: wr=%b done=%b lane=%0d req 1 1 10",
               WR_EN, DONE, LANE_IDX);
    end
    START = 1'b1;
    START_LANE = 4'd11;
    S_DATA = word(6, 1);
    step();
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || S_READY !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b rdy=%b done=%b req 1 1 0",
               BUSY, S_READY, DONE);
    end
    step();
    S_VALID = 1'b0;
    checks++;
    if (WR_EN !== 1'b1 || DONE !== 1'b1 || LANE_IDX !== 4'd11 ||
        WR_DATA !== word(6, 1)) begin
      errors++;
      $display("FAIL b2b_second: wr=%b done=%b lane=%0d data=%h req 1 1 11 %h",
               WR_EN, DONE, LANE_IDX, WR_DATA, word(6, 1));
    end
    step();
  endtask

  task automatic test_abort();
    int dones;
    START = 1'b1;
    START_LANE = 4'd2;
    COUNT = 5'd5;
    S_VALID = 1'b1;
    S_DATA = word(7, 0);
    step();
    START = 1'b0;
    step();
    S_DATA = word(7, 1);
    step();
    checks++;
    if (WR_EN !== 1'b1 || LANE_IDX !== 4'd3) begin
      errors++;
      $display("FAIL abort_pre: wr=%b lane=%0d req 1 3", WR_EN, LANE_IDX);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({S_READY, LANE_IDX, WR_EN, WR_DATA, BUSY, DONE} !== '0) begin
      errors++;
      $display("FAIL abort_async: rdy=%b lane=%0d wr=%b data=%h busy=%b done=%b req all 0",
               S_READY, LANE_IDX, WR_EN, WR_DATA, BUSY, DONE);
    end
    step();
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (WR_EN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle%0d: wr=%b done=%b busy=%b req 0 0 0",
                 i, WR_EN, DONE, BUSY);
      end
    end
    S_VALID = 1'b0;
    test_burst("after_abort", 8, 0, 2, 2);
  endtask

  initial begin
    test_reset();
    test_burst("lane3", 1, 3, 4, 4);
    test_burst("wrap", 2, 14, 4, 4);
    test_empty();
    test_full_clamp();
    test_gaps();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
